program_loader: RTL and testbench

// - Streams a program image from a byte source (UART receiver, host bench) into instruction/data memory.
// - Drives the memory flash port (flash_en/flash_addr/flash_data) directly upstream of the datapath.
// - Holds the core in reset (cpu_hold) while loading, then releases it so fetch starts at BASE_ADDR.

---
 rtl/program_loader.sv | 109 ++++++++++
 tb/tb_program_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed little-endian byte image into memory over the flash port while holding the core in reset.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int               WIDTH     = 32,
  parameter int               MAX_WORDS = 256,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      words_written
);
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE, ERROR
  } state_t;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHECK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, next;
  logic [15:0] len, n;
  logic [1:0] byte_cnt;
  logic [WIDTH-1:0] word;
  logic xfer, go, last, busy_n, rdy_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif
  assign xfer = byte_valid & byte_ready;
  assign n    = {byte_data, len[7:0]};
  assign last = (words_written + 16'd1) == len;
  assign go   = start && (state == IDLE || state == DONE || state == ERROR);
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, ERROR: next = go ? LEN_LO : state;
      LEN_LO: next = xfer ? LEN_HI : state;
      LEN_HI: next = !xfer ? state : n == 16'd0 ? FIN : 32'(n) > 32'(MAX_WORDS) ? ERROR : DATA;
      DATA: next = (xfer && byte_cnt == 2'd3) ? WRITE : state;
      WRITE: next = last ? FIN : DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: next = !xfer ? state : (byte_data == csum) ? DONE : ERROR;
`endif
      default: next = IDLE;
    endcase
    busy_n = !(next == IDLE || next == DONE || next == ERROR);
    rdy_n  = busy_n && next != WRITE;
  end
  // Status outputs are registered copies of what the next state implies, so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready    <= 1'b0;
      flash_en      <= 1'b0;
      flash_addr    <= '0;
      flash_data    <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      len           <= '0;
      byte_cnt      <= '0;
      word          <= '0;
    end else begin
      byte_ready <= rdy_n;
      busy       <= busy_n;
      cpu_hold   <= busy_n;
      done       <= next == DONE;
      error      <= next == ERROR;
      flash_en   <= next == WRITE;
      if (go) begin
        words_written <= '0;
        byte_cnt      <= '0;
      end
      if (xfer && state == LEN_LO) len[7:0] <= byte_data;
      if (xfer && state == LEN_HI) len[15:8] <= byte_data;
      if (xfer && state == DATA) begin
        word[{byte_cnt, 3'b000} +: 8] <= byte_data;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (next == WRITE) begin
        flash_data <= {byte_data, word[23:0]};
        flash_addr <= BASE_ADDR + (WIDTH'(words_written) << 2);
      end
      if (state == WRITE) words_written <= words_written + 16'd1;
    end
  end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk)
    if (rst || go) csum <= '0;
    else if (xfer && state == DATA) csum <= csum ^ byte_data;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
module tb_program_loader;
  logic clk = 1'b0, rst, start, byte_valid;
  logic [7:0] byte_data;
  logic byte_ready, flash_en, cpu_hold, busy, done, error;
  logic [31:0] flash_addr, flash_data;
  logic [15:0] words_written;
  int nvec = 0, nfail = 0;
  logic [31:0] qa[$], qd[$];

  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .flash_en(flash_en), .flash_addr(flash_addr), .flash_data(flash_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (flash_en) begin
      qa.push_back(flash_addr);
      qd.push_back(flash_data);
    end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = byte_ready;
      cyc(1);
    end
    byte_valid = 1'b0;
    nvec++; if (!ok) begin nfail++; $display("FAIL send_byte %h: byte_ready=0 for 40 cycles, required 1", b); end
  endtask

  task automatic wait_end;
    for (int i = 0; i < 30 && !(done || error); i++) cyc(1);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    cyc(2);
    rst = 1'b0;
    nvec++; if (byte_ready !== 1'b0) begin nfail++; $display("FAIL rst_byte_ready got %b want 0", byte_ready); end
    nvec++; if (flash_en !== 1'b0) begin nfail++; $display("FAIL rst_flash_en got %b want 0", flash_en); end
    nvec++; if ({busy, cpu_hold, done, error} !== 4'b0) begin nfail++; $display("FAIL rst_status got %b want 0000", {busy, cpu_hold, done, error}); end
    nvec++; if (words_written !== 16'd0) begin nfail++; $display("FAIL rst_words got %0d want 0", words_written); end
    nvec++; if ({flash_addr, flash_data} !== 64'd0) begin nfail++; $display("FAIL rst_flash_bus got %h want 0", {flash_addr, flash_data}); end
    byte_valid = 1'b1; byte_data = 8'h5A;
    cyc(3);
    byte_valid = 1'b0;
    nvec++; if ({byte_ready, busy} !== 2'b00) begin nfail++; $display("FAIL idle_no_consume got %b want 00", {byte_ready, busy}); end
  endtask

  task automatic test_basic;
    qa.delete(); qd.delete();
    pulse_start;
    nvec++; if ({busy, cpu_hold, done, byte_ready} !== 4'b1101) begin nfail++; $display("FAIL basic_busy got %b want 1101", {busy, cpu_hold, done, byte_ready}); end
    send_byte(8'h02); send_byte(8'h00);
    pulse_start;
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'hD9);
`endif
    wait_end;
    nvec++; if ({done, error, cpu_hold, busy} !== 4'b1000) begin nfail++; $display("FAIL basic_done got %b want 1000", {done, error, cpu_hold, busy}); end
    nvec++; if (words_written !== 16'd2) begin nfail++; $display("FAIL basic_words got %0d want 2", words_written); end
    nvec++; if (byte_ready !== 1'b0) begin nfail++; $display("FAIL basic_ready_done got %b want 0", byte_ready); end
    nvec++; if (qa.size() !== 2) begin nfail++; $display("FAIL basic_nwrites got %0d want 2", qa.size()); end
    if (qa.size() == 2) begin
      nvec++; if (qa[0] !== 32'h0 || qd[0] !== 32'h00A00513) begin nfail++; $display("FAIL basic_w0 got %h/%h want 00000000/00a00513", qa[0], qd[0]); end
      nvec++; if (qa[1] !== 32'h4 || qd[1] !== 32'h0000006F) begin nfail++; $display("FAIL basic_w1 got %h/%h want 00000004/0000006f", qa[1], qd[1]); end
    end
  endtask

  task automatic test_gap;
    qa.delete(); qd.delete();
    pulse_start;
    nvec++; if ({done, words_written} !== 17'd0) begin nfail++; $display("FAIL gap_cleared got %b/%0d want 0/0", done, words_written); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h78); send_byte(8'h56);
    cyc(5);
    nvec++; if ({busy, byte_ready} !== 2'b11 || qa.size() !== 0) begin nfail++; $display("FAIL gap_hold got %b/%0d want 11/0", {busy, byte_ready}, qa.size()); end
    send_byte(8'h34); send_byte(8'h12);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h08);
`endif
    wait_end;
    nvec++; if ({done, error} !== 2'b10 || words_written !== 16'd1) begin nfail++; $display("FAIL gap_done got %b/%0d want 10/1", {done, error}, words_written); end
    nvec++; if (qa.size() !== 1) begin nfail++; $display("FAIL gap_nwrites got %0d want 1", qa.size()); end
    if (qa.size() == 1) begin
      nvec++; if (qa[0] !== 32'h0 || qd[0] !== 32'h12345678) begin nfail++; $display("FAIL gap_w0 got %h/%h want 00000000/12345678", qa[0], qd[0]); end
    end
  endtask

  task automatic test_too_long;
    qa.delete(); qd.delete();
    pulse_start;
    send_byte(8'h01); send_byte(8'h02);
    wait_end;
    nvec++; if ({error, done, busy, cpu_hold} !== 4'b1000) begin nfail++; $display("FAIL long_error got %b want 1000", {error, done, busy, cpu_hold}); end
    nvec++; if (qa.size() !== 0) begin nfail++; $display("FAIL long_nwrites got %0d want 0", qa.size()); end
    byte_valid = 1'b1; byte_data = 8'h99;
    cyc(3);
    byte_valid = 1'b0;
    nvec++; if ({byte_ready, error} !== 2'b01) begin nfail++; $display("FAIL long_idle got %b want 01", {byte_ready, error}); end
  endtask

  task automatic test_zero_len;
    qa.delete(); qd.delete();
    pulse_start;
    nvec++; if (error !== 1'b0) begin nfail++; $display("FAIL zero_err_cleared got %b want 0", error); end
    send_byte(8'h00); send_byte(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_end;
    nvec++; if ({done, error} !== 2'b10 || words_written !== 16'd0 || qa.size() !== 0) begin nfail++; $display("FAIL zero_len got %b/%0d/%0d want 10/0/0", {done, error}, words_written, qa.size()); end
  endtask

  task automatic test_reset_mid;
    qa.delete(); qd.delete();
    pulse_start;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    nvec++; if ({busy, cpu_hold, byte_ready, flash_en, done, error} !== 6'b0) begin nfail++; $display("FAIL mid_rst_status got %b want 000000", {busy, cpu_hold, byte_ready, flash_en, done, error}); end
    cyc(2);
    nvec++; if (qa.size() !== 0 || words_written !== 16'd0) begin nfail++; $display("FAIL mid_rst_nowrite got %0d/%0d want 0/0", qa.size(), words_written); end
    pulse_start;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    wait_end;
    nvec++; if (done !== 1'b1 || qa.size() !== 1) begin nfail++; $display("FAIL mid_reload got %b/%0d want 1/1", done, qa.size()); end
    if (qa.size() == 1) begin
      nvec++; if (qa[0] !== 32'h0 || qd[0] !== 32'hDEADBEEF) begin nfail++; $display("FAIL mid_reload_w0 got %h/%h want 00000000/deadbeef", qa[0], qd[0]); end
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    for (int k = 0; k < 2; k++) begin
      qa.delete(); qd.delete();
      pulse_start;
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      cyc(1);
      nvec++; if ({busy, byte_ready, done} !== 3'b110) begin nfail++; $display("FAIL csum_wait got %b want 110", {busy, byte_ready, done}); end
      send_byte(k == 0 ? 8'h44 : 8'h45);
      wait_end;
      nvec++; if ({done, error} !== (k == 0 ? 2'b10 : 2'b01)) begin nfail++; $display("FAIL csum_result%0d got %b want %b", k, {done, error}, (k == 0 ? 2'b10 : 2'b01)); end
      nvec++; if (qa.size() !== 1) begin nfail++; $display("FAIL csum_nwrites%0d got %0d want 1", k, qa.size()); end
      if (qa.size() == 1) begin
        nvec++; if (qa[0] !== 32'h0 || qd[0] !== 32'h44332211) begin nfail++; $display("FAIL csum_w0_%0d got %h/%h want 00000000/44332211", k, qa[0], qd[0]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_gap;
    test_too_long;
    test_zero_len;
    test_reset_mid;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
